// File: rtl/cpld_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : cpld_pkg
// Description : Shared CPLD types and constants. Holds the watchdog state
//               encoding and the default count-field width.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
package cpld_pkg;

  // Default width of the timeout, pre-timeout and count fields (seconds).
  localparam int CNT_WIDTH_DEF = 8;

  // Watchdog states, 2-bit encoding.
  typedef enum logic [1:0] {
    WDT_IDLE = 2'd0,
    WDT_RUN  = 2'd1,
    WDT_FIRE = 2'd2
  } wdt_state_t;

endpackage : cpld_pkg
`default_nettype wire

// File: rtl/wdt_core_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : wdt_core_if
// Description : Register-side and strobe signals of the watchdog core.
//               The master drives the controls; the slave is the watchdog.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface wdt_core_if #(
  parameter int CNT_WIDTH = cpld_pkg::CNT_WIDTH_DEF
);

  logic                 ce_1hz;
  logic                 ce_8hz;
  logic                 en;
  logic                 lock;
  logic [CNT_WIDTH-1:0] timeout;
  logic [CNT_WIDTH-1:0] pretimeout;
  logic                 kick;
  logic                 irq_ack;
  logic [CNT_WIDTH-1:0] count;
  logic                 irq;
  logic                 wdt_rst;
  logic                 tripped;
  logic                 locked;

  modport master (
    output ce_1hz, ce_8hz, en, lock, timeout, pretimeout, kick, irq_ack,
    input  count, irq, wdt_rst, tripped, locked
  );

  modport slave (
    input  ce_1hz, ce_8hz, en, lock, timeout, pretimeout, kick, irq_ack,
    output count, irq, wdt_rst, tripped, locked
  );

endinterface : wdt_core_if
`default_nettype wire

// File: rtl/wdt_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : wdt_core
// Description : System watchdog. Counts a programmable timeout down on the
//               1 Hz strobe, raises a pre-timeout interrupt, and on expiry
//               drives a fixed-length reset request timed by the 8 Hz strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module wdt_core
  import cpld_pkg::*;
#(
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int PULSE_TICKS = 4
) (
  input  wire         clk,
  input  wire         rst,
  wdt_core_if.slave   bus
);

  // The counter starts at PULSE_TICKS-1 and the pulse ends on the tick that
  // finds it at zero, giving exactly PULSE_TICKS ticks of wdt_rst.
  localparam logic [3:0] c_pulse_load = 4'(PULSE_TICKS - 1);

  wdt_state_t           r_state,   w_state_n;
  logic [CNT_WIDTH-1:0] r_count,   w_count_n;
  logic [3:0]           r_pulse,   w_pulse_n;
  logic                 r_irq,     w_irq_n;
  logic                 r_wdt_rst, w_wdt_rst_n;
  logic                 r_tripped, w_tripped_n;
  logic                 r_locked,  w_locked_n;
  logic                 w_en_eff;
  logic [CNT_WIDTH-1:0] w_count_dec;

  // Once locked, the watchdog behaves as permanently enabled.
  assign w_en_eff    = bus.en | r_locked;
  assign w_count_dec = r_count - CNT_WIDTH'(1);

  // State register and all output registers; rst clears them asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= WDT_IDLE;
      r_count   <= '0;
      r_pulse   <= '0;
      r_irq     <= 1'b0;
      r_wdt_rst <= 1'b0;
      r_tripped <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_count   <= w_count_n;
      r_pulse   <= w_pulse_n;
      r_irq     <= w_irq_n;
      r_wdt_rst <= w_wdt_rst_n;
      r_tripped <= w_tripped_n;
      r_locked  <= w_locked_n;
    end
  end

  // Next-state and next-output logic for the IDLE/RUN/FIRE machine.
  always_comb begin
    w_state_n   = r_state;
    w_count_n   = r_count;
    w_pulse_n   = r_pulse;
    w_irq_n     = r_irq;
    w_wdt_rst_n = r_wdt_rst;
    w_tripped_n = r_tripped;
    w_locked_n  = r_locked;

    // Acknowledge first so that any set event below takes priority.
    if (bus.irq_ack) begin
      w_irq_n = 1'b0;
    end

    unique case (r_state)
      WDT_IDLE: begin
        w_count_n = '0;
        if (w_en_eff) begin
          w_state_n = WDT_RUN;
          w_count_n = bus.timeout;
        end
      end

      WDT_RUN: begin
        if (bus.lock) begin
          w_locked_n = 1'b1;
        end
        if (!w_en_eff) begin
          w_state_n = WDT_IDLE;
          w_count_n = '0;
          w_irq_n   = 1'b0;
        end else if (bus.kick) begin
          w_count_n = bus.timeout;
          w_irq_n   = 1'b0;
        end else if (bus.ce_1hz && (r_count <= CNT_WIDTH'(1))) begin
          // A count of 0 or 1 expires on this strobe, so timeout 0 acts as 1.
          w_state_n   = WDT_FIRE;
          w_count_n   = '0;
          w_wdt_rst_n = 1'b1;
          w_tripped_n = 1'b1;
          w_pulse_n   = c_pulse_load;
        end else if (bus.ce_1hz) begin
          w_count_n = w_count_dec;
          if ((bus.pretimeout != '0) && (w_count_dec == bus.pretimeout)) begin
            w_irq_n = 1'b1;
          end
        end
      end

      WDT_FIRE: begin
        // The reset pulse always runs to completion; only rst can cut it.
        if (bus.ce_8hz) begin
          if (r_pulse == 4'd0) begin
            w_wdt_rst_n = 1'b0;
            w_irq_n     = 1'b0;
            if (w_en_eff) begin
              w_state_n = WDT_RUN;
              w_count_n = bus.timeout;
            end else begin
              w_state_n = WDT_IDLE;
              w_count_n = '0;
            end
          end else begin
            w_pulse_n = r_pulse - 4'd1;
          end
        end
      end

      default: begin
        w_state_n = WDT_IDLE;
        w_count_n = '0;
      end
    endcase
  end

  assign bus.count   = r_count;
  assign bus.irq     = r_irq;
  assign bus.wdt_rst = r_wdt_rst;
  assign bus.tripped = r_tripped;
  assign bus.locked  = r_locked;

endmodule : wdt_core
`default_nettype wire

// File: tb/tb_wdt_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_wdt_core
// Description : Directed self-checking bench for wdt_core with hand-computed
//               expected values.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_wdt_core;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wdt_core_if #(.CNT_WIDTH(8)) bus ();

  wdt_core #(
    .CNT_WIDTH   (8),
    .PULSE_TICKS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_1hz(input logic with_kick, input logic with_ack);
    bus.ce_1hz  = 1'b1;
    bus.kick    = with_kick;
    bus.irq_ack = with_ack;
    tick();
    bus.ce_1hz  = 1'b0;
    bus.kick    = 1'b0;
    bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_8hz();
    bus.ce_8hz = 1'b1;
    tick();
    bus.ce_8hz = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst            = 1'b1;
    bus.ce_1hz     = 1'b0;
    bus.ce_8hz     = 1'b0;
    bus.en         = 1'b0;
    bus.lock       = 1'b0;
    bus.timeout    = 8'd0;
    bus.pretimeout = 8'd0;
    bus.kick       = 1'b0;
    bus.irq_ack    = 1'b0;
    repeat (3) tick();
    check("rst_count",   32'(bus.count),   0);
    check("rst_irq",     32'(bus.irq),     0);
    check("rst_wdt_rst", 32'(bus.wdt_rst), 0);
    check("rst_tripped", 32'(bus.tripped), 0);
    check("rst_locked",  32'(bus.locked),  0);
    rst = 1'b0;
    tick();

    // IDLE ignores strobes and kicks.
    bus.kick = 1'b1;
    pulse_1hz(1'b1, 1'b0);
    check("idle_hold", 32'(bus.count), 0);

    // ---- timeout 3, no pre-timeout, no kicks ----
    bus.timeout = 8'd3;
    bus.en      = 1'b1;
    tick();
    check("s1_load", 32'(bus.count), 3);
    pulse_1hz(1'b0, 1'b0);
    pulse_1hz(1'b0, 1'b0);
    check("s1_cnt1",    32'(bus.count),   1);
    check("s1_norst",   32'(bus.wdt_rst), 0);
    pulse_1hz(1'b0, 1'b0);
    check("s1_fire",    32'(bus.wdt_rst), 1);
    check("s1_tripped", 32'(bus.tripped), 1);
    check("s1_cnt0",    32'(bus.count),   0);
    bus.kick = 1'b1;
    tick();
    bus.kick = 1'b0;
    check("s1_kick_ign", 32'(bus.count), 0);
    for (int i = 0; i < 3; i++) begin
      pulse_8hz();
      check("s1_pulse_hold", 32'(bus.wdt_rst), 1);
    end
    pulse_8hz();
    check("s1_pulse_end", 32'(bus.wdt_rst), 0);
    check("s1_reload",    32'(bus.count),   3);
    check("s1_sticky",    32'(bus.tripped), 1);
    bus.en = 1'b0;
    tick();
    check("s1_idle", 32'(bus.count), 0);

    // ---- timeout 5, pre-timeout 2, kick with 2nd strobe ----
    bus.timeout    = 8'd5;
    bus.pretimeout = 8'd2;
    bus.en         = 1'b1;
    tick();
    check("s2_load", 32'(bus.count), 5);
    pulse_1hz(1'b0, 1'b0);
    check("s2_cnt4", 32'(bus.count), 4);
    pulse_1hz(1'b1, 1'b0);
    check("s2_kick",    32'(bus.count), 5);
    check("s2_kick_irq", 32'(bus.irq),  0);
    pulse_1hz(1'b0, 1'b0);
    pulse_1hz(1'b0, 1'b0);
    check("s2_cnt3",   32'(bus.count), 3);
    check("s2_noirq",  32'(bus.irq),   0);
    pulse_1hz(1'b0, 1'b1);
    check("s2_cnt2",   32'(bus.count), 2);
    check("s2_setwins", 32'(bus.irq),  1);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    check("s2_ack", 32'(bus.irq), 0);
    pulse_1hz(1'b0, 1'b0);
    check("s2_cnt1", 32'(bus.count), 1);
    pulse_1hz(1'b0, 1'b0);
    check("s2_fire", 32'(bus.wdt_rst), 1);
    repeat (4) pulse_8hz();
    check("s2_end",    32'(bus.wdt_rst), 0);
    check("s2_reload", 32'(bus.count),   5);
    bus.en = 1'b0;
    tick();
    check("s2_idle", 32'(bus.count), 0);

    // ---- lock while running ----
    bus.timeout    = 8'd4;
    bus.pretimeout = 8'd0;
    bus.en         = 1'b1;
    tick();
    check("s3_load", 32'(bus.count), 4);
    bus.lock = 1'b1;
    tick();
    bus.lock = 1'b0;
    check("s3_locked", 32'(bus.locked), 1);
    bus.en = 1'b0;
    tick();
    check("s3_stay_run", 32'(bus.count), 4);
    pulse_1hz(1'b0, 1'b0);
    check("s3_countdown", 32'(bus.count),  3);
    check("s3_lock_held", 32'(bus.locked), 1);
    rst = 1'b1;
    #1;
    check("s3_rst_locked", 32'(bus.locked),  0);
    check("s3_rst_count",  32'(bus.count),   0);
    check("s3_rst_trip",   32'(bus.tripped), 0);
    tick();
    rst = 1'b0;
    tick();
    check("s3_idle", 32'(bus.count), 0);

    // ---- en dropped during FIRE ----
    bus.timeout = 8'd1;
    bus.en      = 1'b1;
    tick();
    check("s4_load", 32'(bus.count), 1);
    pulse_1hz(1'b0, 1'b0);
    check("s4_fire", 32'(bus.wdt_rst), 1);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_8hz();
      check("s4_pulse_hold", 32'(bus.wdt_rst), 1);
    end
    pulse_8hz();
    check("s4_end",     32'(bus.wdt_rst), 0);
    check("s4_idle",    32'(bus.count),   0);
    check("s4_tripped", 32'(bus.tripped), 1);
    pulse_1hz(1'b1, 1'b0);
    check("s4_idle_hold", 32'(bus.count), 0);

    // ---- timeout 0 fires on the first strobe; rst mid-pulse ----
    bus.timeout = 8'd0;
    bus.en      = 1'b1;
    tick();
    check("s5_load", 32'(bus.count),   0);
    check("s5_norst", 32'(bus.wdt_rst), 0);
    pulse_1hz(1'b0, 1'b0);
    check("s5_fire", 32'(bus.wdt_rst), 1);
    pulse_8hz();
    check("s5_mid", 32'(bus.wdt_rst), 1);
    #2;
    rst = 1'b1;
    #1;
    check("s5_async_wdt_rst", 32'(bus.wdt_rst), 0);
    check("s5_async_tripped", 32'(bus.tripped), 0);
    check("s5_async_irq",     32'(bus.irq),     0);
    check("s5_async_count",   32'(bus.count),   0);
    check("s5_async_locked",  32'(bus.locked),  0);
    bus.en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("s5_after", 32'(bus.wdt_rst), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_wdt_core
`default_nettype wire
